host_uart_command_enc: RTL and testbench
========================================

HOST_UART_COMMAND_ENC -- requirements
Module: host_uart_command_enc

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low, with ports named clk and reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-low; low forces the reset state immediately.
REQ-004 start  input  1  single-cycle request to encode one command; sampled on the rising edge of clk.
REQ-005 cmd_select  input  16  command to encode: 0x0001 is encrypt-off, 0x0002 is encrypt-on, 0x0003 is read-yaw; all other values are illegal.
REQ-006 input_data  input  256  payload; bits [47:0] carry the 48-bit target device for read-yaw; other bits are ignored.
REQ-007 tx_byte  output  8  current frame byte toward the UART transmitter.
REQ-008 tx_valid  output  1  tx_byte is valid.
REQ-009 tx_ready  input  1  the UART transmitter accepts tx_byte on a cycle where tx_valid and tx_ready are both high.
REQ-010 done  output  1  high when idle and able to accept start.
REQ-011 error  output  1  the last start carried an illegal cmd_select.

Function
REQ-012 Frame bytes SHALL be emitted byte 0 first.
REQ-013 For cmd_select 0x0001, the frame SHALL be 9 bytes: 0x01, 0xFF x6, 0x01, 0x00.
REQ-014 For cmd_select 0x0002, the frame SHALL be 9 bytes: 0x01, 0xFF x6, 0x01, 0x01.
REQ-015 For cmd_select 0x0003, the frame SHALL be 7 bytes: 0x03, then input_data[7:0], [15:8], ... [47:40].
REQ-016 The state machine SHALL have two states, IDLE and SEND.
REQ-017 In IDLE, done=1 and tx_valid=0.
REQ-018 In IDLE, a start with a legal cmd_select SHALL, on that edge, latch the frame into an internal byte buffer, load the byte count (9 or 7), clear error, set done=0, and enter SEND.
REQ-019 In IDLE, a start with an illegal cmd_select SHALL set error=1, keep done=1, emit no bytes, and remain in IDLE.
REQ-020 In SEND, tx_valid=1 and tx_byte=buffer byte 0.
REQ-021 On each handshake in SEND, the buffer SHALL shift by one byte and the count SHALL decrement.
REQ-022 The handshake on the final byte (count=1) SHALL return the block to IDLE on the same edge, so done=1 and tx_valid=0 on the next cycle.
REQ-023 Latency SHALL be fixed: start sampled at edge N gives tx_valid=1 with byte 0 after edge N.
REQ-024 With tx_ready held high, a 9-byte frame SHALL complete in 9 consecutive cycles with no idle gaps.
REQ-025 While tx_valid=1 and tx_ready=0, tx_byte SHALL hold stable and no state SHALL change.
REQ-026 start asserted during SEND SHALL be ignored: no re-latch, no error change, frame unaffected.
REQ-027 start coinciding with the final-byte handshake SHALL be ignored; a new frame requires start while done=1.
REQ-028 error SHALL remain set until the next accepted start or reset.
REQ-029 input_data and cmd_select SHALL be don't-care except on the start edge.

Reset
REQ-030 While reset=0: state=IDLE, tx_valid=0, tx_byte=0x00, done=1, error=0, buffer and count=0.
REQ-031 Reset asserted mid-frame SHALL abort the frame immediately, without waiting for a clock edge.
REQ-032 After reset release, the block SHALL emit no residual bytes and SHALL require a new start.

Verification
REQ-033 Scenario: reset low then high, start with cmd_select=0x0002, tx_ready=1 -> bytes 01 FF FF FF FF FF FF 01 01 on 9 consecutive cycles, then done=1 and error=0.
REQ-034 Scenario: start with cmd_select=0x0003, input_data[47:0]=0x0A0B0C0D0E0F, tx_ready=1 -> bytes 03 0F 0E 0D 0C 0B 0A, then done=1.
REQ-035 Scenario: cmd_select=0x0001 with tx_ready toggling 1,0,0,1,... -> byte stream 01 FF x6 01 00 unchanged, with tx_byte stable during every stall.
REQ-036 Scenario: start with cmd_select=0x0007 -> error=1, done=1, tx_valid stays 0; then start with 0x0001 -> error=0 and a 9-byte frame.
REQ-037 Scenario: start with cmd_select=0x0003 during a 0x0002 frame -> the 0x0002 frame completes intact and no 0x03 frame follows.
REQ-038 Scenario: reset low after the 4th byte of a frame -> tx_valid=0 and done=1 asynchronously, and no bytes appear after release.

Source files
------------

// File: rtl/host_uart_command_enc.sv
// Host command encoder: turns a start request into a byte frame for a UART
// transmitter. The frame is latched whole into a shift buffer on start and
// handed out one byte per valid/ready handshake, byte 0 first.
module host_uart_command_enc (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [15:0]  cmd_select,
  input  logic [255:0] input_data,
  output logic [7:0]   tx_byte,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic         done,
  output logic         error
);

  localparam logic [15:0] CMD_ENCRYPT_OFF = 16'h0001;
  localparam logic [15:0] CMD_ENCRYPT_ON  = 16'h0002;
  localparam logic [15:0] CMD_READ_YAW    = 16'h0003;

  // Six 0xFF bytes shared by both encrypt frames.
  localparam logic [47:0] BROADCAST_ADDR  = 48'hFFFF_FFFF_FFFF;

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [71:0] buffer;
  logic [71:0] buffer_next;
  logic [3:0]  count;
  logic [3:0]  count_next;
  logic        error_next;

  logic        legal_cmd;
  logic [71:0] frame;
  logic [3:0]  frame_len;

  // Only the low 48 payload bits carry a target; the rest is intentionally dropped.
  logic        unused_payload;
  assign unused_payload = ^input_data[255:48];

  // Decode cmd_select into a frame image (byte 0 in the low byte) and its length.
  always_comb begin
    legal_cmd = 1'b1;
    frame     = '0;
    frame_len = '0;
    case (cmd_select)
      CMD_ENCRYPT_OFF: begin
        frame     = {8'h00, 8'h01, BROADCAST_ADDR, 8'h01};
        frame_len = 4'd9;
      end
      CMD_ENCRYPT_ON: begin
        frame     = {8'h01, 8'h01, BROADCAST_ADDR, 8'h01};
        frame_len = 4'd9;
      end
      CMD_READ_YAW: begin
        frame     = {16'h0000, input_data[47:0], 8'h03};
        frame_len = 4'd7;
      end
      default: begin
        legal_cmd = 1'b0;
      end
    endcase
  end

  // Next-state logic: accept starts only in IDLE, shift one byte per handshake in SEND.
  always_comb begin
    state_next  = state;
    buffer_next = buffer;
    count_next  = count;
    error_next  = error;
    case (state)
      IDLE: begin
        if (start) begin
          if (legal_cmd) begin
            buffer_next = frame;
            count_next  = frame_len;
            error_next  = 1'b0;
            state_next  = SEND;
          end else begin
            error_next  = 1'b1;
          end
        end
      end
      SEND: begin
        if (tx_ready) begin
          buffer_next = {8'h00, buffer[71:8]};
          count_next  = count - 4'd1;
          if (count == 4'd1) begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, buffer, count and error registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      buffer <= '0;
      count  <= '0;
      error  <= 1'b0;
    end else begin
      state  <= state_next;
      buffer <= buffer_next;
      count  <= count_next;
      error  <= error_next;
    end
  end

  // Outputs follow the state directly, so a reset drops tx_valid without a clock edge.
  assign tx_valid = (state == SEND);
  assign done     = (state == IDLE);
  assign tx_byte  = tx_valid ? buffer[7:0] : 8'h00;

endmodule

// File: tb/tb_host_uart_command_enc.sv
// Self-checking bench for host_uart_command_enc: directed table of frames,
// hand-written reset-abort sequence, then randomized commands checked
// against a byte-list reference model.
module tb_host_uart_command_enc;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [15:0]  cmd_select;
  logic [255:0] input_data;
  logic [7:0]   tx_byte;
  logic         tx_valid;
  logic         tx_ready;
  logic         done;
  logic         error;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] cmd;
    logic [47:0] data;
    int          mode;
    int          inj_cyc;
    logic [15:0] inj_cmd;
    logic [71:0] exp_frame;
    int          exp_len;
    logic        exp_err;
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  host_uart_command_enc dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .cmd_select (cmd_select),
    .input_data (input_data),
    .tx_byte    (tx_byte),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .done       (done),
    .error      (error)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference: list the frame bytes straight from the command definitions.
  function automatic void model_frame(input logic [15:0] cmd, input logic [255:0] data,
                                      output logic [71:0] frame, output int len, output logic err);
    logic [7:0] b[9];
    frame = '0;
    len   = 0;
    err   = 1'b0;
    for (int i = 0; i < 9; i++) b[i] = 8'h00;
    if (cmd == 16'h0001 || cmd == 16'h0002) begin
      b[0] = 8'h01;
      for (int i = 1; i <= 6; i++) b[i] = 8'hFF;
      b[7] = 8'h01;
      b[8] = (cmd == 16'h0002) ? 8'h01 : 8'h00;
      len  = 9;
    end else if (cmd == 16'h0003) begin
      b[0] = 8'h03;
      for (int i = 1; i <= 6; i++) b[i] = data[(i-1)*8 +: 8];
      len  = 7;
    end else begin
      err = 1'b1;
    end
    for (int i = 0; i < len; i++) frame[i*8 +: 8] = b[i];
  endfunction

  task automatic applyStimulus(input logic [15:0] cmd, input logic [255:0] data);
    start      = 1'b1;
    cmd_select = cmd;
    input_data = data;
    tx_ready   = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
    start      = 1'b0;
    cmd_select = 16'($urandom);
    for (int i = 0; i < 8; i++) input_data[i*32 +: 32] = $urandom;
  endtask

  // mode 0: ready always high, 1: ready 1,0,0 repeating, 2: random ready.
  task automatic runFrame(input logic [15:0] cmd, input logic [255:0] data, input int mode,
                          input int inj_cyc, input logic [15:0] inj_cmd,
                          input logic [71:0] exp_frame, input int exp_len, input logic exp_err);
    int idx;
    int cyc;
    applyStimulus(cmd, data);
    if (exp_err) begin
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        checkOutput("illegal_error", 32'(error), 32'd1);
        checkOutput("illegal_done", 32'(done), 32'd1);
        checkOutput("illegal_valid", 32'(tx_valid), 32'd0);
        @(posedge clk);
        #1;
      end
      return;
    end
    idx = 0;
    cyc = 0;
    while (idx < exp_len && cyc < 200) begin
      case (mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = (cyc % 3 == 0);
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
      if (cyc == inj_cyc) begin
        start      = 1'b1;
        cmd_select = inj_cmd;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      checkOutput("frame_valid", 32'(tx_valid), 32'd1);
      checkOutput("frame_byte", 32'(tx_byte), 32'(exp_frame[idx*8 +: 8]));
      checkOutput("frame_done", 32'(done), 32'd0);
      checkOutput("frame_error", 32'(error), 32'd0);
      @(posedge clk);
      #1;
      if (tx_ready) idx++;
      cyc++;
    end
    start    = 1'b0;
    tx_ready = 1'($urandom_range(0, 1));
    if (idx < exp_len) checkOutput("frame_timeout", 32'(idx), 32'(exp_len));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("post_done", 32'(done), 32'd1);
      checkOutput("post_valid", 32'(tx_valid), 32'd0);
      checkOutput("post_error", 32'(error), 32'd0);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [71:0]  mframe;
    int           mlen;
    logic         merr;
    logic [15:0]  rcmd;
    logic [255:0] rdata;

    vecs[0] = '{16'h0002, 48'h0, 0, -1, 16'h0, 72'h01_01_FFFFFFFFFFFF_01, 9, 1'b0};
    vecs[1] = '{16'h0003, 48'h0A0B0C0D0E0F, 0, -1, 16'h0, 72'h00_0A0B0C0D0E0F_03, 7, 1'b0};
    vecs[2] = '{16'h0001, 48'h0, 1, -1, 16'h0, 72'h00_01_FFFFFFFFFFFF_01, 9, 1'b0};
    vecs[3] = '{16'h0007, 48'h0, 0, -1, 16'h0, 72'h0, 0, 1'b1};
    vecs[4] = '{16'h0001, 48'h0, 0, -1, 16'h0, 72'h00_01_FFFFFFFFFFFF_01, 9, 1'b0};
    vecs[5] = '{16'h0002, 48'h0, 0, 3, 16'h0003, 72'h01_01_FFFFFFFFFFFF_01, 9, 1'b0};
    vecs[6] = '{16'h0003, 48'h123456789ABC, 0, 6, 16'h0007, 72'h00_123456789ABC_03, 7, 1'b0};
    vecs[7] = '{16'h0000, 48'h0, 0, -1, 16'h0, 72'h0, 0, 1'b1};

    reset      = 1'b0;
    start      = 1'b0;
    tx_ready   = 1'b0;
    cmd_select = 16'h0;
    input_data = '0;
    #3;
    checkOutput("reset_valid", 32'(tx_valid), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd1);
    checkOutput("reset_error", 32'(error), 32'd0);
    checkOutput("reset_byte", 32'(tx_byte), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    checkOutput("release_done", 32'(done), 32'd1);
    checkOutput("release_valid", 32'(tx_valid), 32'd0);
    @(posedge clk);
    #1;

    for (int v = 0; v < 8; v++) begin
      runFrame(vecs[v].cmd, {208'h0, vecs[v].data}, vecs[v].mode, vecs[v].inj_cyc,
               vecs[v].inj_cmd, vecs[v].exp_frame, vecs[v].exp_len, vecs[v].exp_err);
    end

    // Error must persist through idle cycles until the next accepted start.
    repeat (5) @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("error_hold", 32'(error), 32'd1);
    @(posedge clk);
    #1;

    // Reset in the middle of a frame, after four bytes have been accepted.
    applyStimulus(16'h0001, '0);
    tx_ready = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    checkOutput("abort_pre_valid", 32'(tx_valid), 32'd1);
    checkOutput("abort_pre_byte", 32'(tx_byte), 32'hFF);
    reset = 1'b0;
    #1;
    checkOutput("abort_valid", 32'(tx_valid), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd1);
    checkOutput("abort_byte", 32'(tx_byte), 32'd0);
    checkOutput("abort_error", 32'(error), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      checkOutput("abort_residual", 32'(tx_valid), 32'd0);
      checkOutput("abort_idle_done", 32'(done), 32'd1);
      @(posedge clk);
      #1;
    end

    // Randomized commands against the reference model.
    for (int r = 0; r < 30; r++) begin
      case ($urandom_range(0, 4))
        0:       rcmd = 16'h0001;
        1:       rcmd = 16'h0002;
        2, 3:    rcmd = 16'h0003;
        default: begin
          rcmd = 16'($urandom);
          if (rcmd >= 16'h0001 && rcmd <= 16'h0003) rcmd = 16'h0100;
        end
      endcase
      for (int i = 0; i < 8; i++) rdata[i*32 +: 32] = $urandom;
      model_frame(rcmd, rdata, mframe, mlen, merr);
      runFrame(rcmd, rdata, 2, -1, 16'h0, mframe, mlen, merr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
